// File: rtl/sa_output_deskew_if.sv
// sa_output_deskew_if: skewed column inputs from the array and the aligned-row valid/ready output.
interface sa_output_deskew_if #(
  parameter int SA_SIZE = 3,
  parameter int WEIGHT_ACTIVATION_SIZE = 8
);
  logic [SA_SIZE-1:0] col_valid;
  logic [SA_SIZE-1:0][WEIGHT_ACTIVATION_SIZE-1:0] col_data;
  logic out_valid;
  logic out_ready;
  logic [SA_SIZE-1:0][WEIGHT_ACTIVATION_SIZE-1:0] out_row;
  modport master (output col_valid, col_data, out_ready, input out_valid, out_row);
  modport slave (input col_valid, col_data, out_ready, output out_valid, out_row);
endinterface

// File: rtl/sa_output_deskew.sv
// sa_output_deskew: aligns skewed array columns into rows and buffers them in a FIFO.
// Optional SA_DESKEW_SKEW_CHECK_EN: require all aligned valids per row and flag skew_err otherwise.
module sa_output_deskew #(
  parameter int SA_SIZE = 3,
  parameter int WEIGHT_ACTIVATION_SIZE = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  sa_output_deskew_if.slave io,
  output logic overflow,
  output logic skew_err,
  output logic [15:0] row_count
);
  localparam int W = WEIGHT_ACTIVATION_SIZE;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;
  typedef logic [SA_SIZE-1:0][W-1:0] row_t;
  logic [SA_SIZE-1:0] al_v;
  row_t al_d;
  genvar j;
  generate
    for (j = 0; j < SA_SIZE; j++) begin : g_col
      localparam int D = SA_SIZE - 1 - j;
      if (D == 0) begin : g_pass
        assign al_v[j] = io.col_valid[j];
        assign al_d[j] = io.col_data[j];
      end else begin : g_dly
        logic [D-1:0] v_q;
        logic [D-1:0][W-1:0] d_q;
        always_ff @(posedge clk or posedge rst) begin
          if (rst) begin
            v_q <= '0;
            d_q <= '0;
          end else begin
            v_q[0] <= io.col_valid[j];
            d_q[0] <= io.col_data[j];
            for (int k = 1; k < D; k++) begin
              v_q[k] <= v_q[k-1];
              d_q[k] <= d_q[k-1];
            end
          end
        end
        assign al_v[j] = v_q[D-1];
        assign al_d[j] = d_q[D-1];
      end
    end
  endgenerate
  logic row_ok, skew_now;
`ifdef SA_DESKEW_SKEW_CHECK_EN
  assign row_ok = &al_v;
  assign skew_now = |al_v && !row_ok;
`else
  assign row_ok = al_v[SA_SIZE-1];
  assign skew_now = 1'b0;
`endif
  logic [AW:0] wp_q, rp_q;
  row_t mem_q [FIFO_DEPTH];
  row_t last_q;
  logic ovf_q, skew_q;
  logic [15:0] cnt_q;
  logic empty, full, pop, push, drop;
  assign empty = wp_q == rp_q;
  assign full = (wp_q[AW] != rp_q[AW]) && (wp_q[AW-1:0] == rp_q[AW-1:0]);
  assign pop = !empty && io.out_ready;
  assign push = row_ok && (!full || pop);
  assign drop = row_ok && full && !pop;
  // Empty FIFO shows the last popped row rather than a stale slot.
  assign io.out_valid = !empty;
  assign io.out_row = empty ? last_q : mem_q[rp_q[AW-1:0]];
  assign overflow = ovf_q;
  assign skew_err = skew_q;
  assign row_count = cnt_q;
  always_ff @(posedge clk) if (push) mem_q[wp_q[AW-1:0]] <= al_d;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp_q <= '0;
      rp_q <= '0;
      last_q <= '0;
      ovf_q <= 1'b0;
      skew_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      if (push) wp_q <= wp_q + PTR_ONE;
      if (push) cnt_q <= cnt_q + 16'd1;
      if (pop) rp_q <= rp_q + PTR_ONE;
      if (pop) last_q <= mem_q[rp_q[AW-1:0]];
      if (drop) ovf_q <= 1'b1;
      if (skew_now) skew_q <= 1'b1;
    end
  end
`ifdef SA_DESKEW_SKEW_CHECK_EN
`ifdef FORMAL
  a_occ: assert property (@(posedge clk) disable iff (rst) (wp_q - rp_q) <= FIFO_DEPTH);
  a_stall: assert property (@(posedge clk) disable iff (rst) io.out_valid && !io.out_ready |=> $stable(io.out_row));
`endif
`endif
endmodule

// File: tb/tb_sa_output_deskew.sv
// tb_sa_output_deskew: directed and randomized checks of sa_output_deskew against a queue-based row model.
module tb_sa_output_deskew;
  localparam int S = 3;
  localparam int W = 8;
  localparam int D = 4;
  localparam int NS = 1024;
  typedef logic [S-1:0][W-1:0] row_t;
  logic clk = 1'b0;
  logic rst;
  logic overflow, skew_err;
  logic [15:0] row_count;
  always #5 clk = ~clk;
  sa_output_deskew_if #(.SA_SIZE(S), .WEIGHT_ACTIVATION_SIZE(W)) io();
  sa_output_deskew #(.SA_SIZE(S), .WEIGHT_ACTIVATION_SIZE(W), .FIFO_DEPTH(D)) dut (
    .clk(clk), .rst(rst), .io(io), .overflow(overflow), .skew_err(skew_err), .row_count(row_count)
  );
  int vectors = 0;
  int errors = 0;
  int cyc = 0;
  logic [S-1:0] cv;
  row_t cd;
  logic rdy;
  logic [S-1:0] fv [NS];
  row_t fd [NS];
  row_t q [$];
  row_t last;
  logic m_ovf, m_skew;
  logic [15:0] m_cnt;
  logic [S-1:0] hv [S];
  row_t hd [S];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    q.delete();
    last = '0;
    m_ovf = 1'b0;
    m_skew = 1'b0;
    m_cnt = '0;
    for (int a = 0; a < S; a++) begin
      hv[a] = '0;
      hd[a] = '0;
    end
    for (int i = 0; i < NS; i++) begin
      fv[i] = '0;
      fd[i] = '0;
    end
  endtask

  // Row of cycle c: column j's sample from c-(S-1-j) cycles, gated by the last column's valid.
  task automatic model_step();
    logic [S-1:0] av;
    row_t ad;
    logic ok, pop;
    int n;
    for (int k = 0; k < S; k++) begin
      av[k] = (k == S - 1) ? cv[k] : hv[S-1-k][k];
      ad[k] = (k == S - 1) ? cd[k] : hd[S-1-k][k];
    end
`ifdef SA_DESKEW_SKEW_CHECK_EN
    ok = &av;
    if (|av && !ok) m_skew = 1'b1;
`else
    ok = av[S-1];
`endif
    n = q.size();
    pop = (n > 0) && rdy;
    if (pop) last = q.pop_front();
    if (ok) begin
      if (n < D || pop) begin
        q.push_back(ad);
        m_cnt = m_cnt + 16'd1;
      end else m_ovf = 1'b1;
    end
    for (int a = S - 1; a > 1; a--) begin
      hv[a] = hv[a-1];
      hd[a] = hd[a-1];
    end
    hv[1] = cv;
    hd[1] = cd;
  endtask

  task automatic compare();
    chk("out_valid", io.out_valid, q.size() > 0);
    chk("out_row", io.out_row, q.size() > 0 ? q[0] : last);
    chk("overflow", overflow, m_ovf);
    chk("skew_err", skew_err, m_skew);
    chk("row_count", row_count, m_cnt);
  endtask

  task automatic step();
    io.col_valid = cv;
    io.col_data = cd;
    io.out_ready = rdy;
    @(negedge clk);
    compare();
    model_step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic launch(input row_t r);
    for (int k = 0; k < S; k++) begin
      fv[(cyc + k) % NS][k] = 1'b1;
      fd[(cyc + k) % NS][k] = r[k];
    end
  endtask

  task automatic step_s();
    cv = fv[cyc % NS];
    cd = fd[cyc % NS];
    fv[cyc % NS] = '0;
    fd[cyc % NS] = '0;
    step();
  endtask

  task automatic step_in(input logic [S-1:0] v, input row_t d);
    cv = v;
    cd = d;
    step();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cv = '0;
    cd = '0;
    io.col_valid = '0;
    io.col_data = '0;
    #1;
    chk("rst_valid", io.out_valid, 0);
    chk("rst_row", io.out_row, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_skew", skew_err, 0);
    chk("rst_count", row_count, 0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc++;
  endtask

  initial begin
    rst = 1'b1;
    cv = '0;
    cd = '0;
    rdy = 1'b0;
    io.col_valid = '0;
    io.col_data = '0;
    io.out_ready = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    chk("init_valid", io.out_valid, 0);
    chk("init_row", io.out_row, 0);
    chk("init_count", row_count, 0);
    rst = 1'b0;
    // single row 6,10,30
    rdy = 1'b1;
    launch({8'd30, 8'd10, 8'd6});
    step_s();
    step_s();
    chk("single_early", io.out_valid, 0);
    step_s();
    chk("single_valid", io.out_valid, 1);
    chk("single_row", io.out_row, 24'h1E0A06);
    chk("single_count", row_count, 1);
    step_s();
    chk("single_drained", io.out_valid, 0);
    // back-to-back rows
    launch({8'd3, 8'd2, 8'd1});
    step_s();
    launch({8'd6, 8'd5, 8'd4});
    step_s();
    step_s();
    chk("b2b_v0", io.out_valid, 1);
    chk("b2b_r0", io.out_row, 24'h030201);
    step_s();
    chk("b2b_v1", io.out_valid, 1);
    chk("b2b_r1", io.out_row, 24'h060504);
    step_s();
    chk("b2b_end", io.out_valid, 0);
    // backpressure with overflow
    do_reset();
    rdy = 1'b0;
    for (int k = 0; k < 5; k++) begin
      launch({8'(k + 2), 8'(k + 1), 8'(k)});
      step_s();
    end
    step_s();
    step_s();
    chk("bp_overflow", overflow, 1);
    chk("bp_count", row_count, 4);
    rdy = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk("bp_drain_v", io.out_valid, 1);
      chk("bp_drain_row", io.out_row, {8'(k + 2), 8'(k + 1), 8'(k)});
      step_s();
    end
    chk("bp_empty", io.out_valid, 0);
    chk("bp_hold_row", io.out_row, 24'h050403);
    // full with simultaneous pop
    do_reset();
    rdy = 1'b0;
    for (int k = 0; k < 4; k++) begin
      launch({8'(k + 2), 8'(k + 1), 8'(k)});
      step_s();
    end
    step_s();
    step_s();
    launch({8'd9, 8'd9, 8'd9});
    step_s();
    step_s();
    rdy = 1'b1;
    step_s();
    chk("fp_overflow", overflow, 0);
    chk("fp_count", row_count, 5);
    for (int k = 1; k < 4; k++) begin
      chk("fp_row", io.out_row, {8'(k + 2), 8'(k + 1), 8'(k)});
      step_s();
    end
    chk("fp_last_v", io.out_valid, 1);
    chk("fp_last", io.out_row, 24'h090909);
    step_s();
    chk("fp_empty", io.out_valid, 0);
    // column 1 one cycle late
    do_reset();
    rdy = 1'b1;
    step_in(3'b001, {8'd0, 8'd0, 8'd7});
    step_in(3'b000, '0);
    step_in(3'b110, {8'd9, 8'd8, 8'd0});
    step_in(3'b000, '0);
    step_in(3'b000, '0);
`ifdef SA_DESKEW_SKEW_CHECK_EN
    chk("skew_flag", skew_err, 1);
    chk("skew_count", row_count, 0);
`else
    chk("skew_flag", skew_err, 0);
    chk("skew_count", row_count, 1);
    chk("skew_row", io.out_row, 24'h090007);
`endif
    // reset with rows buffered and a row in flight
    do_reset();
    rdy = 1'b0;
    launch({8'd1, 8'd1, 8'd1});
    step_s();
    launch({8'd2, 8'd2, 8'd2});
    step_s();
    step_s();
    step_s();
    launch({8'd4, 8'd4, 8'd4});
    step_s();
    step_s();
    chk("mid_count", row_count, 2);
    do_reset();
    rdy = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step_s();
      chk("mid_quiet", io.out_valid, 0);
    end
    launch({8'd3, 8'd3, 8'd3});
    step_s();
    step_s();
    step_s();
    chk("mid_new_v", io.out_valid, 1);
    chk("mid_new_row", io.out_row, 24'h030303);
    // randomized scheduled rows with random backpressure
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 9) < 6) launch(row_t'($urandom));
      rdy = $urandom_range(0, 3) != 0;
      if (i % 300 < 60) rdy = 1'b0;
      step_s();
      if (i == 777) do_reset();
    end
    for (int i = 0; i < 4; i++) step_s();
    // unconstrained column traffic
    for (int i = 0; i < 1000; i++) begin
      rdy = $urandom_range(0, 1);
      step_in(S'($urandom), row_t'($urandom));
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
